// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants and the buffered {pc, inst} entry layout.
package fetch_unit_pkg;
  localparam int          InstAddrW     = 32;
  localparam int          InstW         = 32;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic        ChipEnable    = 1'b1;
  localparam logic        ChipDisable   = 1'b0;
  localparam int          FetchBufDepth = 4;
  localparam logic [31:0] PcStep        = 32'd4;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer with flush; head reads as zero when empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FetchBufDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [63:0]            din,
  output logic [$clog2(DEPTH):0] count,
  output logic [63:0]            head
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// PC owner and ROM driver feeding a small instruction buffer toward IF/ID.
// Optional feature: define FETCH_BYPASS_EN for a zero-latency empty-buffer bypass.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = FetchBufDepth,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [31:0]            rom_addr,
  input  logic [31:0]            rom_inst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] buf_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  pc, redirect_tgt;
  logic         ce_q, fifo_empty, fifo_full;
  logic         fifo_push, fifo_pop, fetch, take;
  logic [63:0]  head_raw;
  fetch_entry_t head, wr_entry;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign fifo_empty   = (buf_count == '0);
  assign fifo_full    = (buf_count == CW'(DEPTH));
  assign head         = fetch_entry_t'(head_raw);
  assign wr_entry     = '{pc: pc, inst: rom_inst};

  // A redirect kills both the capture and any handshake on the head.
  assign fifo_pop  = !redirect_valid && !fifo_empty && out_ready;
  assign fetch     = ce_q && !redirect_valid && (!fifo_full || fifo_pop);
  assign fifo_push = fetch && !take;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && ce_q && !redirect_valid;
  assign take      = bypass && out_ready;
  assign out_valid = bypass || !fifo_empty;
  assign out_pc    = bypass ? pc       : head.pc;
  assign out_inst  = bypass ? rom_inst : head.inst;
`else
  assign take      = 1'b0;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= RESET_PC;
      ce_q <= ChipDisable;
    end else begin
      ce_q <= ChipEnable;
      if (redirect_valid) pc <= redirect_tgt;
      else if (fetch)     pc <= pc + PcStep;
    end
  end

  assign rom_ce   = ce_q;
  assign rom_addr = pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_entry),
    .count (buf_count),
    .head  (head_raw)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: table of per-cycle vectors plus corner sequences.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, rdy, rd;
  logic [31:0] rpc;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  buf_count;

  logic        rst_w, rdy_w;
  logic        rom_ce_w, out_valid_w;
  logic [31:0] rom_addr_w, rom_inst_w, out_pc_w, out_inst_w;
  logic [2:0]  buf_count_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM model: word i holds 32'h1000_0000 + i
  assign rom_inst   = 32'h1000_0000 + {2'b00, rom_addr[31:2]};
  assign rom_inst_w = 32'h1000_0000 + {2'b00, rom_addr_w[31:2]};

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .redirect_valid(rd), .redirect_pc(rpc), .out_valid(out_valid), .out_ready(rdy),
    .out_pc(out_pc), .out_inst(out_inst), .buf_count(buf_count)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst_w), .rom_ce(rom_ce_w), .rom_addr(rom_addr_w), .rom_inst(rom_inst_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(out_valid_w), .out_ready(rdy_w),
    .out_pc(out_pc_w), .out_inst(out_inst_w), .buf_count(buf_count_w)
  );

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ce;
    logic        ov;
    logic [2:0]  cnt;
    logic [31:0] opc;
    logic [31:0] oinst;
    logic [31:0] addr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic y, input logic d, input logic [31:0] p,
                     input logic ce, input logic ov, input logic [2:0] cnt,
                     input logic [31:0] opc, input logic [31:0] oi, input logic [31:0] ad);
    vec_t v;
    v = '{r, y, d, p, ce, ov, cnt, opc, oi, ad};
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic chk_main(input int step, input logic ce, input logic ov, input logic [2:0] cnt,
                          input logic [31:0] opc, input logic [31:0] oi, input logic [31:0] ad);
    chk("rom_ce", step, {31'b0, rom_ce}, {31'b0, ce});
    chk("out_valid", step, {31'b0, out_valid}, {31'b0, ov});
    chk("buf_count", step, {29'b0, buf_count}, {29'b0, cnt});
    chk("out_pc", step, out_pc, opc);
    chk("out_inst", step, out_inst, oi);
    chk("rom_addr", step, rom_addr, ad);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rdy = 1'b0; rd = 1'b0; rpc = '0;
    rst_w = 1'b0; rdy_w = 1'b0;
    repeat (2) @(negedge clk);
    chk_main(-1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);

`ifdef FETCH_BYPASS_EN
    rst = 1'b1; rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_main(0, 1'b1, 1'b1, 3'd0, 32'h0, 32'h1000_0000, 32'h0);
    @(posedge clk); @(negedge clk);
    chk_main(1, 1'b1, 1'b1, 3'd0, 32'h4, 32'h1000_0001, 32'h4);
    rdy = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_main(2, 1'b1, 1'b1, 3'd1, 32'h4, 32'h1000_0001, 32'h8);
`else
    // fields: rst_n rdy redirect rpc | ce out_valid cnt out_pc out_inst rom_addr
    add(1,1,0,0,        1,0,0,32'h0,  32'h0,         32'h0);
    add(1,1,0,0,        1,1,1,32'h0,  32'h1000_0000, 32'h4);
    add(1,1,0,0,        1,1,1,32'h4,  32'h1000_0001, 32'h8);
    add(1,1,0,0,        1,1,1,32'h8,  32'h1000_0002, 32'hC);
    add(1,1,0,0,        1,1,1,32'hC,  32'h1000_0003, 32'h10);
    add(1,1,0,0,        1,1,1,32'h10, 32'h1000_0004, 32'h14);
    add(1,0,0,0,        1,1,2,32'h10, 32'h1000_0004, 32'h18);
    add(1,0,0,0,        1,1,3,32'h10, 32'h1000_0004, 32'h1C);
    add(1,1,1,32'h103,  1,0,0,32'h0,  32'h0,         32'h100);
    add(1,1,0,0,        1,1,1,32'h100,32'h1000_0040, 32'h104);
    add(1,1,0,0,        1,1,1,32'h104,32'h1000_0041, 32'h108);
    add(0,1,0,0,        0,0,0,32'h0,  32'h0,         32'h0);
    add(1,0,0,0,        1,0,0,32'h0,  32'h0,         32'h0);
    add(1,0,0,0,        1,1,1,32'h0,  32'h1000_0000, 32'h4);
    add(1,0,0,0,        1,1,2,32'h0,  32'h1000_0000, 32'h8);
    add(1,0,0,0,        1,1,3,32'h0,  32'h1000_0000, 32'hC);
    for (int k = 0; k < 7; k++)
      add(1,0,0,0,      1,1,4,32'h0,  32'h1000_0000, 32'h10);
    add(1,1,0,0,        1,1,4,32'h4,  32'h1000_0001, 32'h14);
    add(1,1,0,0,        1,1,4,32'h8,  32'h1000_0002, 32'h18);
    add(1,1,0,0,        1,1,4,32'hC,  32'h1000_0003, 32'h1C);
    add(1,1,0,0,        1,1,4,32'h10, 32'h1000_0004, 32'h20);

    foreach (tv[i]) begin
      rst = tv[i].rst_n; rdy = tv[i].rdy; rd = tv[i].rd; rpc = tv[i].rpc;
      @(posedge clk); @(negedge clk);
      chk_main(i, tv[i].ce, tv[i].ov, tv[i].cnt, tv[i].opc, tv[i].oinst, tv[i].addr);
    end

    // reset while full must clear outputs without a clock edge
    rst = 1'b0; rdy = 1'b0;
    #1;
    chk("async_rst out_valid", 100, {31'b0, out_valid}, 32'h0);
    chk("async_rst rom_ce", 100, {31'b0, rom_ce}, 32'h0);
    chk("async_rst buf_count", 100, {29'b0, buf_count}, 32'h0);
    chk("async_rst rom_addr", 100, rom_addr, 32'h0);

    // PC wrap-around from RESET_PC = FFFF_FFF8
    @(negedge clk);
    rst_w = 1'b1; rdy_w = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wrap rom_ce", 200, {31'b0, rom_ce_w}, 32'h1);
    @(posedge clk); @(negedge clk);
    chk("wrap out_pc", 201, out_pc_w, 32'hFFFF_FFF8);
    chk("wrap out_inst", 201, out_inst_w, 32'h4FFF_FFFE);
    @(posedge clk); @(negedge clk);
    chk("wrap out_pc", 202, out_pc_w, 32'hFFFF_FFFC);
    chk("wrap rom_addr", 202, rom_addr_w, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("wrap out_pc", 203, out_pc_w, 32'h0);
    chk("wrap out_inst", 203, out_inst_w, 32'h1000_0000);
    chk("wrap rom_addr", 203, rom_addr_w, 32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that owns the program counter, drives the instruction ROM's chip-enable and address, and buffers the returned words with their PCs in a small FIFO. It sits directly upstream of the instruction ROM and between the ROM and the IF/ID pipeline register. It decouples ROM reads from downstream stalls through a valid/ready output handshake, and it accepts branch/exception redirects that flush buffered instructions.

## Interface
Parameters:
- DEPTH, 4, instruction buffer entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rom_ce  out  1  ROM chip-enable (`ChipEnable`/`ChipDisable`), registered.
- rom_addr  out  32  byte address to the ROM; equals the PC.
- rom_inst  in  32  ROM data, combinational from rom_addr in the same cycle.
- redirect_valid  in  1  load redirect_pc and flush the buffer.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry this cycle.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  instruction of the head entry.
- buf_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Reset (rst=0): pc=RESET_PC, rom_ce=0, buffer empty, buf_count=0, out_valid=0, out_pc=0, out_inst=`ZeroWord`.
- After reset release, rom_ce goes to 1 on the first rising edge and stays at 1.
- Push: when rom_ce=1, there is no redirect, and the buffer has room, the {pc, rom_inst} pair is written at the edge and pc advances by 4.
  - The buffer has room when buf_count<DEPTH, or when buf_count==DEPTH and a pop occurs in the same cycle.
- Pop: when out_valid && out_ready, the head entry is removed at the edge.
- Simultaneous push and pop: buf_count is unchanged.
- Full with no pop: pc holds and rom_addr is stable.
- Redirect has priority over push and pop:
  - the buffer is cleared and pc is loaded with {redirect_pc[31:2],2'b00};
  - no instruction is captured that cycle;
  - any handshake on the current head in that cycle is ignored and the entry is discarded.
- PC wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. This is not an error.
- out_valid = (buf_count!=0). out_pc and out_inst show the head entry and are 0 when the buffer is empty.
- Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Normal fetch latency: the ROM word addressed in cycle N appears at the output with out_valid=1 in cycle N+1.
- Redirect asserted in cycle N:
  - cycle N+1: rom_addr equals the target and out_valid=0;
  - cycle N+2: the target instruction is at the output.
- Throughput is one instruction per cycle while out_ready=1.
- out_* are driven from registers/FIFO storage; there is no combinational path from rom_inst to out_* (except as described under Configuration).
- Asserting reset mid-operation immediately clears all state and drops rom_ce. Nothing is captured during reset.

## Configuration
- Macro FETCH_BYPASS_EN.
- Defined: when the buffer is empty, rom_ce=1, and there is no redirect:
  - out_valid=1, out_pc=pc and out_inst=rom_inst combinationally;
  - if out_ready=1, the word is consumed without entering the buffer and pc advances;
  - otherwise it is pushed as normal;
  - the fetch-to-output latency becomes 0 cycles.
- Not defined: every instruction passes through the buffer with 1-cycle latency, as above.

## Structure
- Shared defines header (existing) holds `ZeroWord`, `ChipEnable`, `ChipDisable`, `InstAddrBus` and `InstBus`.
- Add `FetchBufDepth` (default 4) and `PcStep` (4) to the same header.
- One sub-module, fetch_fifo: a DEPTH×64-bit synchronous FIFO with flush, push, pop, count and head outputs. fetch_unit holds the PC, the rom_ce register, push/pop arbitration and the bypass logic.

## Test plan
- Reset, then release with ROM words 0..7 = 32'h1000_0000+i and out_ready=1:
  - rom_ce rises 1 cycle after release;
  - out_pc sequence is 0,4,8,…;
  - out_inst matches the ROM contents;
  - one instruction per cycle.
- out_ready=0 for 10 cycles from an empty buffer:
  - buf_count saturates at 4 and pc holds at 32'h10;
  - after out_ready=1 the outputs resume in order at 0,4,8,C,10.
- Full buffer, out_ready=1 for one cycle: simultaneous push and pop, buf_count stays 4, pc advances by 4.
- With 3 entries buffered, redirect_valid=1 with redirect_pc=32'h0000_0103:
  - next cycle: buf_count=0, out_valid=0, rom_addr=32'h100;
  - the cycle after: out_pc=32'h100.
- RESET_PC=32'hFFFF_FFF8: output PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst while the buffer is full mid-stream: out_valid=0, rom_ce=0 and buf_count=0 immediately, without waiting for a clock edge.
- With FETCH_BYPASS_EN defined, an empty buffer and out_ready=1: out_valid=1 in the same cycle rom_addr=0 is presented.
